mmio_arbiter: RTL

Two-master arbiter for the processor's memory-mapped data bus. Shares the single-cycle slaves (dmem, factorial accelerator, gpio, FP wrapper) between master 0 (the mips core) and master 1 (a secondary requester: debug loader or DMA). It decodes the granted master's address into the per-slave write strobes and the read-mux select, and returns registered read data and an acknowledge to the owning master. It sits between the masters and the existing strobe decode / `mux4` read path, replacing the direct core-to-decoder connection.

---
 rtl/mmio_arbiter_if.sv | 42 ++++
 rtl/mmio_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mmio_arbiter_if.sv
// rtl/mmio_arbiter_if.sv - master-side and slave-side bus signals of the two-master MMIO arbiter
interface mmio_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1m;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_we;
  logic          wem;
  logic          wef;
  logic          weg;
  logic          wep;
  logic [1:0]    rdsel;
  logic [DW-1:0] s_rdata;

  // arbiter view: serves master requests and drives the slave side
  modport slave (
    input  req0, req1, we0, we1m, addr0, addr1, wdata0, wdata1, s_rdata,
    output gnt0, gnt1, ack0, ack1, rdata0, rdata1,
    output s_addr, s_wdata, s_we, wem, wef, weg, wep, rdsel
  );

  modport master (
    output req0, req1, we0, we1m, addr0, addr1, wdata0, wdata1, s_rdata,
    input  gnt0, gnt1, ack0, ack1, rdata0, rdata1,
    input  s_addr, s_wdata, s_we, wem, wef, weg, wep, rdsel
  );
endinterface

// File: rtl/mmio_arbiter.sv
// rtl/mmio_arbiter.sv - two-master MMIO arbiter with slave decode; MMIO_ARB_FAIR_EN bounds bursts to BURST_MAX
module mmio_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BURST_MAX = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  mmio_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last;
  logic          w_last_nxt;
  logic          r_ack0;
  logic          r_ack1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          w_own0;
  logic          w_own1;
  logic          w_valid0;
  logic          w_valid1;
  logic          w_valid;
  logic          w_we;
  logic          w_wr;
  logic          w_hand0;
  logic          w_hand1;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [1:0]    w_rdsel;
  logic          w_wem;
  logic          w_wef;
  logic          w_weg;
  logic          w_wep;

  if (BURST_MAX < 1) begin : g_burst_max_invalid
    $error("mmio_arbiter: BURST_MAX must be at least 1");
  end

  assign w_own0   = (r_state == OWN0);
  assign w_own1   = (r_state == OWN1);
  assign w_valid0 = w_own0 & bus.req0;
  assign w_valid1 = w_own1 & bus.req1;
  assign w_valid  = w_valid0 | w_valid1;

`ifdef MMIO_ARB_FAIR_EN
  localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  assign w_hand0 = (r_cnt == CNT_MAX) & bus.req1;
  assign w_hand1 = (r_cnt == CNT_MAX) & bus.req0;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_cnt <= '0;
    else      r_cnt <= w_cnt_nxt;
  end

  // count restarts on every change of owner and saturates while the owner stays
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_state_nxt != r_state || w_state_nxt == IDLE) w_cnt_nxt = '0;
    else if (r_cnt != CNT_MAX)                         w_cnt_nxt = r_cnt + 1'b1;
  end
`else
  assign w_hand0 = 1'b0;
  assign w_hand1 = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_ack0  <= w_valid0;
      r_ack1  <= w_valid1;
      if (w_valid0 && !bus.we0)  r_rdata0 <= bus.s_rdata;
      if (w_valid1 && !bus.we1m) r_rdata1 <= bus.s_rdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (bus.req0 && bus.req1) w_state_nxt = r_last ? OWN0 : OWN1;
        else if (bus.req0)        w_state_nxt = OWN0;
        else if (bus.req1)        w_state_nxt = OWN1;
      end
      OWN0: begin
        if (!bus.req0)   w_state_nxt = bus.req1 ? OWN1 : IDLE;
        else if (w_hand0) w_state_nxt = OWN1;
      end
      OWN1: begin
        if (!bus.req1)   w_state_nxt = bus.req0 ? OWN0 : IDLE;
        else if (w_hand1) w_state_nxt = OWN0;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt == OWN0) w_last_nxt = 1'b0;
    if (w_state_nxt == OWN1) w_last_nxt = 1'b1;
  end

  assign w_addr  = w_own0 ? bus.addr0  : (w_own1 ? bus.addr1  : '0);
  assign w_wdata = w_own0 ? bus.wdata0 : (w_own1 ? bus.wdata1 : '0);
  assign w_we    = w_own0 ? bus.we0    : (w_own1 ? bus.we1m   : 1'b0);
  assign w_wr    = w_we & w_valid;

  // an idle bus presents address 0, which lands on the dmem select
  always_comb begin
    w_rdsel = 2'b01;
    w_wem   = 1'b0;
    w_wef   = 1'b0;
    w_weg   = 1'b0;
    w_wep   = 1'b0;
    case (w_addr[11:8])
      4'h8:    begin w_rdsel = 2'b10; w_wef = w_wr; end
      4'h9:    begin w_rdsel = 2'b11; w_weg = w_wr; end
      4'hA:    begin w_rdsel = 2'b00; w_wep = w_wr; end
      default: begin w_rdsel = 2'b01; w_wem = w_wr; end
    endcase
  end

  assign bus.gnt0    = w_own0;
  assign bus.gnt1    = w_own1;
  assign bus.ack0    = r_ack0;
  assign bus.ack1    = r_ack1;
  assign bus.rdata0  = r_rdata0;
  assign bus.rdata1  = r_rdata1;
  assign bus.s_addr  = w_addr;
  assign bus.s_wdata = w_wdata;
  assign bus.s_we    = w_wr;
  assign bus.wem     = w_wem;
  assign bus.wef     = w_wef;
  assign bus.weg     = w_weg;
  assign bus.wep     = w_wep;
  assign bus.rdsel   = w_rdsel;

endmodule
